// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction fetch stage. Issues one instruction-memory request at a time,
// waits for the response, and presents the fetched word to the IF/ID register
// until it is consumed (fetch_valid=1 and stall=0). A redirect pulse has
// priority over everything else. If the redirect arrives while a request is
// in flight, that request's response is marked for dropping.
//
// Parameters
//   RESET_PC     first fetch address after reset
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   stall        downstream hold of the presented instruction
//   redirect     one-cycle branch/jump/flush pulse, target on redirect_pc
//   imem_req     request valid (REQ state only), imem_addr = internal pc
//   imem_gnt     memory accepted the request this cycle
//   imem_rvalid  response valid, data on imem_rdata
//   instr_out    fetched instruction, pc_out is its address
//   fetch_valid  instr_out/pc_out valid
//   misalign     misaligned redirect target flag
//
// Configuration
//   MISALIGN_TRAP_EN  when defined, a redirect to a target that is not word
//                     aligned sets misalign and parks in FAULT until an
//                     aligned redirect arrives. When undefined, the low two
//                     target bits are cleared and misalign is tied 0.
// -----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        fetch_valid,
    output logic        misalign
);

`ifdef MISALIGN_TRAP_EN
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_FAULT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;
`endif

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] instr_nxt, pc_out_nxt;
    logic        drop, drop_nxt;
    logic        fv_nxt;
    logic [31:0] target;

`ifdef MISALIGN_TRAP_EN
    logic        mis_nxt;
    assign target = redirect_pc;
`else
    assign target   = redirect_pc & 32'hFFFF_FFFC;
    assign misalign = 1'b0;
`endif

    // Only one request can be outstanding, so the request is simply "in REQ".
    assign imem_req  = (state == S_REQ);
    assign imem_addr = pc;

    // NOTE: every variable gets its hold value first so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        drop_nxt   = drop;
        instr_nxt  = instr_out;
        pc_out_nxt = pc_out;
        fv_nxt     = fetch_valid;
`ifdef MISALIGN_TRAP_EN
        mis_nxt    = misalign;
`endif

        if (redirect) begin
            fv_nxt   = 1'b0;
            drop_nxt = 1'b0;
`ifdef MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) begin
                mis_nxt   = 1'b1;
                state_nxt = S_FAULT;
            end else begin
                mis_nxt   = 1'b0;
`else
            begin
`endif
                pc_nxt    = target;
                state_nxt = S_REQ;
                // A request accepted now, or still in flight, returns a word
                // for the old path: remember to throw it away.
                if (state == S_REQ && imem_gnt) begin
                    drop_nxt  = 1'b1;
                    state_nxt = S_WAIT;
                end else if (state == S_WAIT && !imem_rvalid) begin
                    drop_nxt  = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
        end else begin
            unique case (state)
                S_IDLE: state_nxt = S_REQ;
                S_REQ: begin
                    if (imem_gnt) state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        drop_nxt = 1'b0;
                        if (drop) begin
                            state_nxt = S_REQ;
                        end else begin
                            instr_nxt  = imem_rdata;
                            pc_out_nxt = pc;
                            fv_nxt     = 1'b1;
                            pc_nxt     = pc + 32'd4;  // wraps modulo 2^32
                            state_nxt  = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        fv_nxt    = 1'b0;
                        state_nxt = S_REQ;
                    end
                end
`ifdef MISALIGN_TRAP_EN
                S_FAULT: state_nxt = S_FAULT;
`endif
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            drop        <= 1'b0;
            instr_out   <= 32'h0;
            pc_out      <= 32'h0;
            fetch_valid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign    <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            drop        <= drop_nxt;
            instr_out   <= instr_nxt;
            pc_out      <= pc_out_nxt;
            fetch_valid <= fv_nxt;
`ifdef MISALIGN_TRAP_EN
            misalign    <= mis_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Bench for if_fetch_unit. The bench plays the instruction memory: it grants
// requests at random, answers after a random latency, and returns a word
// derived from the address. It also injects stray responses.
//
// The reference model only tracks the architectural instruction stream:
//   - the address the next delivered instruction must have,
//   - which word memory holds at that address,
//   - the hold/consume/redirect rules for the presented instruction.
// Directed steps cover reset, the sequential stream, stall hold, redirects
// during WAIT and coincident with a response, reset mid-WAIT, pc wrap and
// misaligned targets. A randomized run follows the directed steps.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        fetch_valid;
    logic        misalign;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_out(instr_out), .pc_out(pc_out), .fetch_valid(fetch_valid),
        .misalign(misalign)
    );

    int n_cmp = 0;
    int n_err = 0;

    // memory model
    bit          pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_cnt = 0;
    bit          hs_seen = 1'b0;

    // stimulus knobs (percentages / latency range)
    int p_gnt = 100, p_stall = 0, p_redir = 0, p_spur = 0, lat_min = 1, lat_max = 1;
    bit          redir_once = 1'b0;
    logic [31:0] redir_once_pc = 32'h0;

    // reference model of the instruction stream
    logic [31:0] exp_pc = RESET_PC;
    bit          exp_mis = 1'b0;
    int          n_deliv = 0;
    bit          prev_fv = 1'b0, prev_stall = 1'b0, prev_redir = 1'b0;
    logic [31:0] prev_pc_out = 32'h0, prev_instr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_redirect(input logic [31:0] t);
`ifdef MISALIGN_TRAP_EN
        if (t[1:0] != 2'b00) exp_mis = 1'b1;
        else begin
            exp_mis = 1'b0;
            exp_pc  = t;
        end
`else
        exp_pc = {t[31:2], 2'b00};
`endif
    endtask

    function automatic logic [31:0] rand_target();
`ifdef MISALIGN_TRAP_EN
        return $urandom() & 32'hFFFF_FFFC;
`else
        return $urandom();
`endif
    endfunction

    // One clock: sample and check at the falling edge, then drive inputs.
    task automatic cycle();
        @(negedge clk);
        check("misalign", misalign, exp_mis);
        if (imem_req) begin
            check("req_addr", imem_addr, exp_pc);
            check("one_outstanding", pend, 1'b0);
        end
        if (exp_mis) check("fault_no_req", imem_req, 1'b0);
        if (fetch_valid) check("valid_no_req", imem_req, 1'b0);
        if (prev_redir) begin
            check("redirect_kills", fetch_valid, 1'b0);
        end else if (fetch_valid && !prev_fv) begin
            check("deliver_pc", pc_out, exp_pc);
            check("deliver_instr", instr_out, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_deliv++;
        end else if (prev_fv) begin
            if (prev_stall) begin
                check("hold_valid", fetch_valid, 1'b1);
                check("hold_pc", pc_out, prev_pc_out);
                check("hold_instr", instr_out, prev_instr);
            end else begin
                check("consume_clears", fetch_valid, 1'b0);
            end
        end
        prev_fv     = fetch_valid;
        prev_pc_out = pc_out;
        prev_instr  = instr_out;

        imem_rvalid = 1'b0;
        imem_rdata  = $urandom();
        if (pend) begin
            if (pend_cnt <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
                pend        = 1'b0;
            end else begin
                pend_cnt--;
            end
        end else if ($urandom_range(99) < p_spur) begin
            imem_rvalid = 1'b1;
        end
        imem_gnt = ($urandom_range(99) < p_gnt);
        hs_seen  = 1'b0;
        if (imem_req && imem_gnt) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_cnt  = $urandom_range(lat_max, lat_min);
            hs_seen   = 1'b1;
        end
        stall    = ($urandom_range(99) < p_stall);
        redirect = 1'b0;
        if (redir_once) begin
            redirect    = 1'b1;
            redirect_pc = redir_once_pc;
            redir_once  = 1'b0;
        end else if ($urandom_range(99) < p_redir) begin
            redirect    = 1'b1;
            redirect_pc = rand_target();
        end
        if (redirect) apply_redirect(redirect_pc);
        prev_stall = stall;
        prev_redir = redirect;
    endtask

    task automatic run_until_deliv(input string tag, input int n, input int budget);
        int goal;
        int k;
        goal = n_deliv + n;
        k = 0;
        while (n_deliv < goal && k < budget) begin
            cycle();
            k++;
        end
        check({tag, "_timeout"}, 32'(n_deliv >= goal), 32'd1);
    endtask

    task automatic run_until_req(input string tag, input int budget);
        int k;
        k = 0;
        while (!imem_req && k < budget) begin
            cycle();
            k++;
        end
        check({tag, "_timeout"}, imem_req, 1'b1);
    endtask

    task automatic wait_hs(input string tag, input int budget);
        int k;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!hs_seen && k < budget);
        check({tag, "_timeout"}, hs_seen, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"}, imem_req, 1'b0);
        check({tag, "_addr"}, imem_addr, RESET_PC);
        check({tag, "_valid"}, fetch_valid, 1'b0);
        check({tag, "_pc_out"}, pc_out, 32'h0);
        check({tag, "_instr"}, instr_out, 32'h0);
        check({tag, "_misalign"}, misalign, 1'b0);
    endtask

    initial begin
        int start_deliv;

        // reset state
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // sequential stream, gnt tied 1, response one cycle after gnt
        run_until_deliv("seq", 4, 40);

        // stall for 5 cycles while holding the instruction at 0x10
        p_stall = 100;
        run_until_deliv("stall_fetch", 1, 20);
        check("stall_pc", pc_out, 32'h10);
        repeat (4) cycle();
        check("stall_still_valid", fetch_valid, 1'b1);
        check("stall_no_req", imem_req, 1'b0);
        p_stall = 0;
        run_until_req("stall_resume", 20);
        check("stall_next_addr", imem_addr, 32'h14);

        // redirect in WAIT, response two cycles later must be dropped
        lat_min = 3; lat_max = 3;
        wait_hs("wait_hs", 20);
        redir_once = 1'b1; redir_once_pc = 32'h100;
        cycle();
        run_until_req("redir_wait", 20);
        check("redir_wait_addr", imem_addr, 32'h100);
        run_until_deliv("redir_wait_fetch", 1, 20);

        // redirect coincident with the response
        lat_min = 1; lat_max = 1;
        wait_hs("coinc_hs", 20);
        redir_once = 1'b1; redir_once_pc = 32'h240;
        cycle();
        run_until_req("redir_coinc", 20);
        check("redir_coinc_addr", imem_addr, 32'h240);
        run_until_deliv("redir_coinc_fetch", 1, 20);

        // reset mid-WAIT, stale response after release
        lat_min = 3; lat_max = 3;
        wait_hs("rst_hs", 20);
        cycle();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midwait_reset");
        pend = 1'b0; imem_gnt = 1'b0; redirect = 1'b0; stall = 1'b0;
        prev_fv = 1'b0; prev_stall = 1'b0; prev_redir = 1'b0;
        exp_pc = RESET_PC;
        @(negedge clk);
        rst_n = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        lat_min = 1; lat_max = 1;
        run_until_deliv("post_reset", 2, 40);

        // pc wraps modulo 2^32
        redir_once = 1'b1; redir_once_pc = 32'hFFFF_FFF8;
        run_until_deliv("wrap", 3, 40);
        check("wrap_pc_out", pc_out, 32'h0000_0000);

        // misaligned redirect target, issued from HOLD
        p_stall = 100;
        run_until_deliv("mis_hold", 1, 20);
        redir_once = 1'b1; redir_once_pc = 32'h102;
        p_stall = 0;
        cycle();
`ifdef MISALIGN_TRAP_EN
        repeat (4) cycle();
        check("mis_set", misalign, 1'b1);
        check("mis_no_req", imem_req, 1'b0);
        redir_once = 1'b1; redir_once_pc = 32'h200;
        cycle();
        run_until_req("mis_clear", 20);
        check("mis_clear_addr", imem_addr, 32'h200);
        check("mis_cleared", misalign, 1'b0);
`else
        run_until_req("mis_forced", 20);
        check("mis_forced_addr", imem_addr, 32'h100);
        check("mis_tied", misalign, 1'b0);
`endif

        // randomized traffic
        p_gnt = 70; lat_min = 1; lat_max = 3; p_stall = 30; p_redir = 4; p_spur = 10;
        start_deliv = n_deliv;
        repeat (800) cycle();
        check("random_progress", 32'(n_deliv > start_deliv + 20), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  downstream hold; an instruction is consumed in a cycle with fetch_valid=1 and stall=0.
REQ-005 redirect  input  1  branch/jump/flush request, one-cycle pulse.
REQ-006 redirect_pc  input  32  target of redirect.
REQ-007 imem_req  output  1  instruction memory request valid.
REQ-008 imem_addr  output  32  request address, equal to the internal pc.
REQ-009 imem_gnt  input  1  memory accepted the request this cycle.
REQ-010 imem_rvalid  input  1  response data valid.
REQ-011 imem_rdata  input  32  response instruction word.
REQ-012 instr_out  output  32  fetched instruction presented to the IF/ID register.
REQ-013 pc_out  output  32  address of instr_out.
REQ-014 fetch_valid  output  1  instr_out/pc_out valid.
REQ-015 misalign  output  1  misaligned redirect target flag (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, HOLD, plus FAULT when MISALIGN_TRAP_EN is defined.
REQ-017 IDLE: imem_req=0; next state REQ unconditionally.
REQ-018 REQ: imem_req=1, imem_addr=pc; on imem_gnt go to WAIT, else stay in REQ.
REQ-019 At most one request SHALL be outstanding; imem_req=0 in WAIT, HOLD and FAULT.
REQ-020 WAIT with imem_rvalid and no drop pending: instr_out<=imem_rdata, pc_out<=pc, fetch_valid<=1, pc<=pc+4, go to HOLD.
REQ-021 HOLD: outputs held stable while stall=1; when stall=0, fetch_valid<=0 and go to REQ (next request issued the following cycle).
REQ-022 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 redirect SHALL have priority over stall and over all other transitions.
REQ-024 redirect in IDLE, REQ without gnt, or HOLD: pc<=redirect_pc, fetch_valid<=0, go to REQ.
REQ-025 redirect in REQ with imem_gnt in the same cycle: pc<=redirect_pc, set drop, go to WAIT.
REQ-026 redirect in WAIT without imem_rvalid: pc<=redirect_pc, set drop, stay in WAIT.
REQ-027 imem_rvalid in WAIT with drop set, or coincident with redirect: response discarded, fetch_valid stays 0, drop cleared, go to REQ with the new pc.
REQ-028 imem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-029 rst_n low SHALL immediately force pc=RESET_PC, state=IDLE, drop=0, imem_req=0, instr_out=0, pc_out=0, fetch_valid=0, misalign=0, including while a request is outstanding.
REQ-030 A response arriving after reset release for a pre-reset request SHALL be ignored (state is not WAIT).

Configuration
REQ-031 Macro MISALIGN_TRAP_EN: when defined, redirect with redirect_pc[1:0]!=0 sets misalign=1, fetch_valid<=0, and enters FAULT (no requests); only a redirect with an aligned target clears misalign and goes to REQ.
REQ-032 When MISALIGN_TRAP_EN is undefined, redirect_pc[1:0] is forced to 2'b00, misalign is tied 0, and FAULT does not exist.

Verification
REQ-033 Reset release, imem_gnt tied 1, rvalid one cycle after gnt, rdata=32'h0000_0013 -> first fetch_valid with pc_out=0, then pc_out=4, 8, ...
REQ-034 stall=1 for 5 cycles while fetch_valid=1 at pc_out=32'h10 -> outputs constant, imem_req=0, next imem_addr=32'h14 after stall drops.
REQ-035 redirect to 32'h100 in WAIT, rvalid 2 cycles later with rdata=32'hDEAD_BEEF -> word discarded, next imem_addr=32'h100.
REQ-036 redirect coincident with rvalid -> no fetch_valid; next request address equals redirect_pc.
REQ-037 With MISALIGN_TRAP_EN, redirect to 32'h102 -> misalign=1, no imem_req; redirect to 32'h200 -> misalign=0, imem_addr=32'h200.
REQ-038 rst_n asserted mid-WAIT, then rvalid after release -> ignored, fetch restarts at RESET_PC.
